ppu_oam_dma: RTL and testbench

Sprite-attribute DMA controller and OAM write arbiter for the PPU. On a CPU trigger it copies 64 32-bit sprite records from a word-addressed source memory into OAM, moving data only while the display is in vertical blank. It owns the PPU's OAM write port (object index, data, write strobe) and shares it between the DMA engine and direct CPU single-record writes, with DMA taking priority.

---
 rtl/ppu_pkg.sv | 28 ++
 rtl/ppu_oam_dma_if.sv | 44 ++++
 rtl/ppu_oam_dma.sv | 114 +++++++++++
 tb/tb_ppu_oam_dma.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ppu_pkg.sv
//------------------------------------------------------------------
// ppu_pkg - shared PPU types and constants (rev 1.0)
//------------------------------------------------------------------
`default_nettype none

package ppu_pkg;

  localparam int NUM_SPRITES = 64;
  localparam int OAM_IDX_W   = 6;
  localparam int OAM_REC_W   = 32;

  // Bit offsets of the byte fields inside one OAM record
  localparam int REC_X_LSB    = 0;
  localparam int REC_Y_LSB    = 8;
  localparam int REC_TILE_LSB = 16;
  localparam int REC_PAL_LSB  = 24;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WAIT_VB = 3'd1,
    REQ     = 3'd2,
    DATA    = 3'd3,
    DONE    = 3'd4
  } dma_state_e;

endpackage

`default_nettype wire

// File: rtl/ppu_oam_dma_if.sv
//------------------------------------------------------------------
// ppu_oam_dma_if - source-read bus, CPU write port and OAM port (rev 1.0)
//------------------------------------------------------------------
`default_nettype none

interface ppu_oam_dma_if #(
  parameter int SRC_AW = 16
);
  import ppu_pkg::*;

  logic                 mem_req;
  logic [SRC_AW-1:0]    mem_addr;
  logic                 mem_gnt;
  logic                 mem_rvalid;
  logic [OAM_REC_W-1:0] mem_rdata;

  logic                 cpu_wr_req;
  logic [OAM_IDX_W-1:0] cpu_wr_idx;
  logic [OAM_REC_W-1:0] cpu_wr_data;
  logic                 cpu_wr_ack;

  logic [OAM_IDX_W-1:0] oam_idx;
  logic [OAM_REC_W-1:0] oam_data;
  logic                 oam_write;

  modport master (
    output mem_req, mem_addr,
    input  mem_gnt, mem_rvalid, mem_rdata,
    input  cpu_wr_req, cpu_wr_idx, cpu_wr_data,
    output cpu_wr_ack,
    output oam_idx, oam_data, oam_write
  );

  modport slave (
    input  mem_req, mem_addr,
    output mem_gnt, mem_rvalid, mem_rdata,
    output cpu_wr_req, cpu_wr_idx, cpu_wr_data,
    input  cpu_wr_ack,
    input  oam_idx, oam_data, oam_write
  );

endinterface

`default_nettype wire

// File: rtl/ppu_oam_dma.sv
//------------------------------------------------------------------
// ppu_oam_dma - vblank-gated sprite-record DMA and OAM write arbiter (rev 1.0)
//------------------------------------------------------------------
`default_nettype none

module ppu_oam_dma
  import ppu_pkg::*;
#(
  parameter int SRC_AW = 16
) (
  input  wire logic              clk,
  input  wire logic              reset,
  input  wire logic              vblank,
  input  wire logic              dma_start,
  input  wire logic [SRC_AW-1:0] dma_src_base,
  output logic                   dma_busy,
  output logic                   dma_done,
  ppu_oam_dma_if.master          bus
);

  localparam logic [OAM_IDX_W-1:0] LAST_IDX = OAM_IDX_W'(NUM_SPRITES - 1);

  dma_state_e           state, state_nxt;
  logic [OAM_IDX_W-1:0] idx, idx_nxt;
  logic [SRC_AW-1:0]    base, base_nxt;
  logic                 dma_wr;
  logic                 cpu_serve;

  // The CPU only owns the OAM port while the engine is not fetching, so the
  // write mux below is selected purely by state and never collides.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    base_nxt  = base;
    dma_wr    = 1'b0;
    cpu_serve = bus.cpu_wr_req && !bus.cpu_wr_ack &&
                ((state == IDLE) || (state == WAIT_VB));

    case (state)
      IDLE: begin
        if (dma_start) begin
          base_nxt  = dma_src_base;
          idx_nxt   = '0;
          state_nxt = WAIT_VB;
        end
      end
      WAIT_VB: begin
        if (vblank) state_nxt = REQ;
      end
      REQ: begin
        // An ungranted request is withdrawn as soon as vblank is lost
        if (bus.mem_gnt)  state_nxt = DATA;
        else if (!vblank) state_nxt = WAIT_VB;
      end
      DATA: begin
        if (bus.mem_rvalid) begin
          dma_wr = 1'b1;
          if (idx == LAST_IDX) begin
            state_nxt = DONE;
          end else begin
            idx_nxt   = idx + OAM_IDX_W'(1);
            state_nxt = vblank ? REQ : WAIT_VB;
          end
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      idx   <= '0;
      base  <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      base  <= base_nxt;
    end
  end

  // Outputs are registered from the next state; busy drops together with the
  // done pulse so software never sees done while busy is still set.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dma_busy       <= 1'b0;
      dma_done       <= 1'b0;
      bus.mem_req    <= 1'b0;
      bus.mem_addr   <= '0;
      bus.cpu_wr_ack <= 1'b0;
      bus.oam_idx    <= '0;
      bus.oam_data   <= '0;
      bus.oam_write  <= 1'b0;
    end else begin
      dma_busy       <= (state_nxt != IDLE) && (state_nxt != DONE);
      dma_done       <= (state_nxt == DONE);
      bus.mem_req    <= (state_nxt == REQ);
      bus.mem_addr   <= base_nxt + SRC_AW'(idx_nxt);
      bus.cpu_wr_ack <= cpu_serve;
      bus.oam_write  <= dma_wr || cpu_serve;
      if (dma_wr) begin
        bus.oam_idx  <= idx;
        bus.oam_data <= bus.mem_rdata;
      end else if (cpu_serve) begin
        bus.oam_idx  <= bus.cpu_wr_idx;
        bus.oam_data <= bus.cpu_wr_data;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ppu_oam_dma.sv
//------------------------------------------------------------------
// tb_ppu_oam_dma - directed self-checking bench for ppu_oam_dma (rev 1.0)
//------------------------------------------------------------------
`default_nettype none

module tb_ppu_oam_dma;
  import ppu_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        vblank = 1'b0;
  logic        dma_start = 1'b0;
  logic [15:0] dma_src_base = 16'h0;
  logic        dma_busy;
  logic        dma_done;

  ppu_oam_dma_if #(.SRC_AW(16)) bus();

  ppu_oam_dma #(.SRC_AW(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .vblank       (vblank),
    .dma_start    (dma_start),
    .dma_src_base (dma_src_base),
    .dma_busy     (dma_busy),
    .dma_done     (dma_done),
    .bus          (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  idx;
    logic [31:0] data;
    bit          cpu;
    int          cyc;
  } wr_t;

  wr_t         wr_q[$];
  logic [15:0] gnt_q[$];
  wr_t         w;
  int          cyc = 0;
  int          tests = 0;
  int          fails = 0;
  int          viol = 0;
  int          gnt_mode = 0;
  int          stall = -1;
  bit          gnt_pending = 1'b0;
  logic [15:0] gnt_addr = 16'h0;
  bit          prev_vb = 1'b0;

  function automatic logic [31:0] src_word(input logic [15:0] a);
    return {8'hA5, a[7:0] ^ 8'h5A, a};
  endfunction

  // Source memory: grant policy plus read data one cycle after each grant
  always @(posedge clk) begin
    cyc++;
    #1;
    bus.mem_rvalid = gnt_pending;
    bus.mem_rdata  = gnt_pending ? src_word(gnt_addr) : 32'h0;
    if (gnt_mode == 0) begin
      bus.mem_gnt = 1'b1;
    end else if (!bus.mem_req) begin
      bus.mem_gnt = 1'b0;
      stall = -1;
    end else begin
      if (stall < 0) stall = $urandom_range(0, 5);
      if (stall == 0) begin
        bus.mem_gnt = 1'b1;
        stall = -1;
      end else begin
        bus.mem_gnt = 1'b0;
        stall--;
      end
    end
  end

  always @(negedge clk) begin
    if (bus.mem_req && bus.mem_gnt) begin
      gnt_pending = 1'b1;
      gnt_addr    = bus.mem_addr;
      gnt_q.push_back(bus.mem_addr);
    end else begin
      gnt_pending = 1'b0;
    end
    if (bus.mem_req && !vblank && !prev_vb) viol++;
    if (bus.oam_write) begin
      w.idx  = bus.oam_idx;
      w.data = bus.oam_data;
      w.cpu  = bus.cpu_wr_ack;
      w.cyc  = cyc;
      wr_q.push_back(w);
    end
    prev_vb = vblank;
  end

  task automatic start_dma(input logic [15:0] b, output int t);
    @(posedge clk); #1;
    dma_src_base = b;
    dma_start    = 1'b1;
    t            = cyc;
    @(posedge clk); #1;
    dma_start    = 1'b0;
  endtask

  task automatic wait_done(input int bound, output int dc, output bit ok);
    ok = 1'b0;
    dc = -1;
    for (int i = 0; i < bound; i++) begin
      @(posedge clk); #1;
      if (dma_done) begin
        dc = cyc;
        ok = 1'b1;
        break;
      end
    end
    @(negedge clk); #1;
  endtask

  task automatic clear_logs();
    wr_q.delete();
    gnt_q.delete();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests++; if (dma_busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %0b want 0", dma_busy); end
    tests++; if (dma_done !== 1'b0) begin fails++; $display("FAIL reset_done got %0b want 0", dma_done); end
    tests++; if (bus.mem_req !== 1'b0) begin fails++; $display("FAIL reset_mem_req got %0b want 0", bus.mem_req); end
    tests++; if (bus.mem_addr !== 16'h0) begin fails++; $display("FAIL reset_mem_addr got %h want 0000", bus.mem_addr); end
    tests++; if (bus.cpu_wr_ack !== 1'b0) begin fails++; $display("FAIL reset_ack got %0b want 0", bus.cpu_wr_ack); end
    tests++; if (bus.oam_idx !== 6'd0) begin fails++; $display("FAIL reset_oam_idx got %0d want 0", bus.oam_idx); end
    tests++; if (bus.oam_data !== 32'h0) begin fails++; $display("FAIL reset_oam_data got %h want 0", bus.oam_data); end
    tests++; if (bus.oam_write !== 1'b0) begin fails++; $display("FAIL reset_oam_write got %0b want 0", bus.oam_write); end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_full_dma();
    int t, dc, n, last_c;
    bit ok;
    vblank = 1'b1; gnt_mode = 0; clear_logs();
    start_dma(16'h0100, t);
    tests++; if (dma_busy !== 1'b1) begin fails++; $display("FAIL full_busy_t1 got %0b want 1", dma_busy); end
    @(posedge clk); #1;
    tests++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 16'h0100) begin
      fails++; $display("FAIL full_req_t2 got req=%0b addr=%h want req=1 addr=0100", bus.mem_req, bus.mem_addr); end
    wait_done(400, dc, ok);
    tests++; if (!ok || dc != t + 130) begin fails++; $display("FAIL full_done_cycle got %0d want %0d", dc - t, 130); end
    n = 0; last_c = -1;
    foreach (wr_q[i]) if (!wr_q[i].cpu) begin
      tests++;
      if (wr_q[i].idx !== 6'(n) || wr_q[i].data !== src_word(16'h0100 + 16'(n))) begin
        fails++; $display("FAIL full_rec%0d got idx=%0d data=%h want idx=%0d data=%h",
                          n, wr_q[i].idx, wr_q[i].data, n, src_word(16'h0100 + 16'(n))); end
      last_c = wr_q[i].cyc; n++;
    end
    tests++; if (n != 64) begin fails++; $display("FAIL full_count got %0d want 64", n); end
    tests++; if (last_c != t + 130) begin fails++; $display("FAIL full_last_write got %0d want 130", last_c - t); end
  endtask

  task automatic test_vblank_drop();
    int t, dc, n;
    bit ok, found, req_seen;
    vblank = 1'b1; gnt_mode = 0; clear_logs();
    start_dma(16'h0200, t);
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (bus.mem_req && bus.mem_gnt && bus.mem_addr == 16'h020A) found = 1'b1;
    end
    tests++; if (!found) begin fails++; $display("FAIL vb_find_gnt10 got none want grant of 020A"); end
    @(posedge clk); #1; vblank = 1'b0;
    @(posedge clk); #1;
    tests++; if (bus.oam_write !== 1'b1 || bus.oam_idx !== 6'd10 || bus.mem_req !== 1'b0) begin
      fails++; $display("FAIL vb_rec10 got wr=%0b idx=%0d req=%0b want wr=1 idx=10 req=0",
                        bus.oam_write, bus.oam_idx, bus.mem_req); end
    req_seen = 1'b0;
    repeat (49) begin @(posedge clk); #1; if (bus.mem_req) req_seen = 1'b1; end
    tests++; if (req_seen || dma_busy !== 1'b1) begin
      fails++; $display("FAIL vb_parked got req_seen=%0b busy=%0b want 0 1", req_seen, dma_busy); end
    vblank = 1'b1;
    wait_done(400, dc, ok);
    tests++; if (!ok) begin fails++; $display("FAIL vb_done got timeout want done"); end
    tests++; if (gnt_q.size() != 64 || gnt_q[11] !== 16'h020B) begin
      fails++; $display("FAIL vb_resume got grants=%0d g11=%h want 64 020B", gnt_q.size(), gnt_q[11]); end
    n = 0;
    foreach (wr_q[i]) if (!wr_q[i].cpu) begin
      tests++;
      if (wr_q[i].idx !== 6'(n) || wr_q[i].data !== src_word(16'h0200 + 16'(n))) begin
        fails++; $display("FAIL vb_rec%0d got idx=%0d data=%h", n, wr_q[i].idx, wr_q[i].data); end
      n++;
    end
    tests++; if (n != 64) begin fails++; $display("FAIL vb_count got %0d want 64", n); end
  endtask

  task automatic test_wrap();
    int t, dc;
    bit ok;
    vblank = 1'b1; gnt_mode = 0; clear_logs();
    start_dma(16'hFFF0, t);
    wait_done(400, dc, ok);
    tests++; if (!ok || gnt_q.size() != 64) begin
      fails++; $display("FAIL wrap_done got ok=%0b grants=%0d want 1 64", ok, gnt_q.size()); end
    foreach (gnt_q[k]) begin
      tests++;
      if (gnt_q[k] !== 16'hFFF0 + 16'(k)) begin
        fails++; $display("FAIL wrap_addr%0d got %h want %h", k, gnt_q[k], 16'hFFF0 + 16'(k)); end
    end
  endtask

  task automatic test_arbitration();
    int t, dc, ac, n, ncpu;
    bit ok, acked;
    vblank = 1'b1; gnt_mode = 0; clear_logs();
    start_dma(16'h0300, t);
    @(posedge clk); #1;
    bus.cpu_wr_req  = 1'b1;
    bus.cpu_wr_idx  = 6'd5;
    bus.cpu_wr_data = 32'h11223344;
    dma_src_base    = 16'h0400;
    dma_start       = 1'b1;
    dc = -1; ac = -1; acked = 1'b0;
    for (int i = 0; i < 400 && !acked; i++) begin
      @(posedge clk); #1;
      dma_start = 1'b0;
      if (dma_done) dc = cyc;
      if (bus.cpu_wr_ack) begin
        ac = cyc; acked = 1'b1;
        tests++; if (bus.oam_write !== 1'b1 || bus.oam_idx !== 6'd5 || bus.oam_data !== 32'h11223344) begin
          fails++; $display("FAIL arb_cpu_write got wr=%0b idx=%0d data=%h want 1 5 11223344",
                            bus.oam_write, bus.oam_idx, bus.oam_data); end
      end
    end
    bus.cpu_wr_req = 1'b0;
    tests++; if (!acked || dc < 0 || ac != dc + 2) begin
      fails++; $display("FAIL arb_ack_cycle got ack=%0d done=%0d want ack=done+2", ac, dc); end
    @(posedge clk); #1;
    tests++; if (dma_busy !== 1'b0) begin fails++; $display("FAIL arb_no_restart got busy=%0b want 0", dma_busy); end
    @(negedge clk);
    n = 0; ncpu = 0;
    foreach (wr_q[i]) begin
      if (wr_q[i].cpu) ncpu++;
      else begin
        tests++;
        if (wr_q[i].idx !== 6'(n) || wr_q[i].data !== src_word(16'h0300 + 16'(n))) begin
          fails++; $display("FAIL arb_rec%0d got idx=%0d data=%h", n, wr_q[i].idx, wr_q[i].data); end
        n++;
      end
    end
    tests++; if (n != 64 || ncpu != 1) begin
      fails++; $display("FAIL arb_counts got dma=%0d cpu=%0d want 64 1", n, ncpu); end
  endtask

  task automatic test_cpu_rate();
    bit exp_ack[4];
    bit got;
    exp_ack = '{1'b1, 1'b0, 1'b1, 1'b0};
    @(posedge clk); #1;
    bus.cpu_wr_req  = 1'b1;
    bus.cpu_wr_idx  = 6'd9;
    bus.cpu_wr_data = 32'hCAFEF00D;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      got = bus.cpu_wr_ack;
      tests++; if (got !== exp_ack[k] || bus.oam_write !== exp_ack[k]) begin
        fails++; $display("FAIL cpu_rate_c%0d got ack=%0b wr=%0b want %0b", k + 1, got, bus.oam_write, exp_ack[k]); end
      if (k == 0) begin
        tests++; if (bus.oam_idx !== 6'd9 || bus.oam_data !== 32'hCAFEF00D) begin
          fails++; $display("FAIL cpu_rate_data got idx=%0d data=%h want 9 CAFEF00D", bus.oam_idx, bus.oam_data); end
      end
    end
    bus.cpu_wr_req = 1'b0;
    @(posedge clk);
  endtask

  task automatic test_reset_mid();
    int t, dc, n;
    bit ok, hit;
    vblank = 1'b1; gnt_mode = 0; clear_logs();
    start_dma(16'h0500, t);
    hit = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(posedge clk); #1;
      if (bus.oam_write && bus.oam_idx == 6'd30) hit = 1'b1;
    end
    tests++; if (!hit) begin fails++; $display("FAIL rstmid_find got none want write idx 30"); end
    reset = 1'b0;
    #1;
    tests++; if ({dma_busy, dma_done, bus.mem_req, bus.cpu_wr_ack, bus.oam_write} !== 5'b0 ||
                 bus.mem_addr !== 16'h0 || bus.oam_idx !== 6'd0 || bus.oam_data !== 32'h0) begin
      fails++; $display("FAIL rstmid_outputs got busy=%0b done=%0b req=%0b addr=%h wr=%0b idx=%0d data=%h want all 0",
                        dma_busy, dma_done, bus.mem_req, bus.mem_addr, bus.oam_write, bus.oam_idx, bus.oam_data); end
    @(posedge clk); @(posedge clk); #3;
    reset = 1'b1;
    clear_logs();
    start_dma(16'h0600, t);
    wait_done(400, dc, ok);
    tests++; if (!ok || dc != t + 130) begin fails++; $display("FAIL rstmid_done got %0d want 130", dc - t); end
    n = 0;
    foreach (wr_q[i]) if (!wr_q[i].cpu) begin
      tests++;
      if (wr_q[i].idx !== 6'(n) || wr_q[i].data !== src_word(16'h0600 + 16'(n))) begin
        fails++; $display("FAIL rstmid_rec%0d got idx=%0d data=%h", n, wr_q[i].idx, wr_q[i].data); end
      n++;
    end
    tests++; if (n != 64) begin fails++; $display("FAIL rstmid_count got %0d want 64", n); end
  endtask

  task automatic test_random();
    int t, dc, n;
    bit ok, stop;
    vblank = 1'b1; gnt_mode = 1; clear_logs(); viol = 0; stop = 1'b0;
    start_dma(16'h0700, t);
    fork
      begin
        wait_done(20000, dc, ok);
        stop = 1'b1;
      end
      begin
        while (!stop) begin
          repeat ($urandom_range(2, 15)) @(posedge clk);
          #1; vblank = ~vblank;
        end
      end
    join
    vblank = 1'b1; gnt_mode = 0;
    tests++; if (!ok) begin fails++; $display("FAIL rand_done got timeout want done"); end
    tests++; if (gnt_q.size() != 64) begin fails++; $display("FAIL rand_grants got %0d want 64", gnt_q.size()); end
    tests++; if (viol != 0) begin fails++; $display("FAIL rand_req_outside_vblank got %0d want 0", viol); end
    n = 0;
    foreach (wr_q[i]) if (!wr_q[i].cpu) begin
      tests++;
      if (wr_q[i].idx !== 6'(n) || wr_q[i].data !== src_word(16'h0700 + 16'(n))) begin
        fails++; $display("FAIL rand_rec%0d got idx=%0d data=%h", n, wr_q[i].idx, wr_q[i].data); end
      n++;
    end
    tests++; if (n != 64) begin fails++; $display("FAIL rand_count got %0d want 64", n); end
  endtask

  initial begin
    bus.mem_gnt     = 1'b0;
    bus.mem_rvalid  = 1'b0;
    bus.mem_rdata   = 32'h0;
    bus.cpu_wr_req  = 1'b0;
    bus.cpu_wr_idx  = 6'd0;
    bus.cpu_wr_data = 32'h0;
    test_reset();
    test_full_dma();
    test_vblank_drop();
    test_wrap();
    test_arbitration();
    test_cpu_rate();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
